// File: rtl/lsu_sram_ctrl.sv
// Load/store unit: captures one memory instruction, runs a request/response
// handshake with the data SRAM and returns a one-cycle ack with extended load data.
module lsu_sram_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       addr,
    input  logic [31:0]       st_data,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [3:0]        bmask,
    input  logic [2:0]        ld_sel,
    output logic              ack,
    output logic [31:0]       ld_data,
    output logic              lsu_err,
    output logic              sram_req,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    output logic [3:0]        sram_bmask,
    input  logic [31:0]       sram_rdata,
    input  logic              sram_rvalid
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       addr_lo_q;
    logic [2:0]       ld_sel_q;
    logic             is_wr_q;

    logic             ack_q;
    logic             lsu_err_q;
    logic [31:0]      ld_data_q;
    logic             sram_req_q;
    logic             sram_we_q;
    logic [ADDR_W-1:0] sram_addr_q;
    logic [31:0]      sram_wdata_q;
    logic [3:0]       sram_bmask_q;

    logic             misaligned;
    logic [3:0]       bmask_shifted;
    logic [31:0]      wdata_shifted;
    logic [31:0]      rword_shifted;
    logic [31:0]      load_ext;
    logic             unused_addr_hi;

    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    // Alignment is judged on the incoming request; stores use bmask, loads use ld_sel.
    always_comb begin
        misaligned = 1'b0;
        if (wr_en) begin
            if (bmask == 4'b0011)
                misaligned = addr[0];
            else if (bmask == 4'b1111)
                misaligned = (addr[1:0] != 2'b00);
        end else begin
            if (ld_sel == LD_LH || ld_sel == LD_LHU)
                misaligned = addr[0];
            else if (ld_sel == LD_LW)
                misaligned = (addr[1:0] != 2'b00);
        end
    end

    assign bmask_shifted = bmask << addr[1:0];
    assign wdata_shifted = st_data << {addr[1:0], 3'b000};
    assign rword_shifted = sram_rdata >> {addr_lo_q, 3'b000};

    always_comb begin
        load_ext = 32'h0;
        case (ld_sel_q)
            LD_LB:   load_ext = {{24{rword_shifted[7]}}, rword_shifted[7:0]};
            LD_LH:   load_ext = {{16{rword_shifted[15]}}, rword_shifted[15:0]};
            LD_LW:   load_ext = rword_shifted;
            LD_LBU:  load_ext = {24'h0, rword_shifted[7:0]};
            LD_LHU:  load_ext = {16'h0, rword_shifted[15:0]};
            default: load_ext = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            addr_lo_q    <= 2'b00;
            ld_sel_q     <= 3'b000;
            is_wr_q      <= 1'b0;
            ack_q        <= 1'b0;
            lsu_err_q    <= 1'b0;
            ld_data_q    <= 32'h0;
            sram_req_q   <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= 32'h0;
            sram_bmask_q <= 4'b0000;
        end else begin
            // ack, error and load data are single-cycle pulses
            ack_q     <= 1'b0;
            lsu_err_q <= 1'b0;
            ld_data_q <= 32'h0;
            case (state_q)
                ST_IDLE: begin
                    if (rd_en || wr_en) begin
                        addr_lo_q <= addr[1:0];
                        ld_sel_q  <= ld_sel;
                        is_wr_q   <= wr_en;
                        if (misaligned) begin
                            state_q   <= ST_DONE;
                            ack_q     <= 1'b1;
                            lsu_err_q <= 1'b1;
                        end else begin
                            state_q      <= ST_REQ;
                            cnt_q        <= '0;
                            sram_req_q   <= 1'b1;
                            sram_we_q    <= wr_en;
                            sram_addr_q  <= addr[ADDR_W+1:2];
                            sram_wdata_q <= wdata_shifted;
                            sram_bmask_q <= wr_en ? bmask_shifted : 4'b0000;
                        end
                    end
                end
                ST_REQ: begin
                    if (sram_rvalid) begin
                        state_q      <= ST_DONE;
                        sram_req_q   <= 1'b0;
                        sram_we_q    <= 1'b0;
                        sram_bmask_q <= 4'b0000;
                        ack_q        <= 1'b1;
                        ld_data_q    <= is_wr_q ? 32'h0 : load_ext;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q      <= ST_DONE;
                        sram_req_q   <= 1'b0;
                        sram_we_q    <= 1'b0;
                        sram_bmask_q <= 4'b0000;
                        ack_q        <= 1'b1;
                        lsu_err_q    <= 1'b1;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    // Never re-samples rd_en/wr_en: one instruction, one access
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ack        = ack_q;
    assign lsu_err    = lsu_err_q;
    assign ld_data    = ld_data_q;
    assign sram_req   = sram_req_q;
    assign sram_we    = sram_we_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign sram_bmask = sram_bmask_q;

endmodule
